topdown_counter_bank: RTL
=========================

# topdown_counter_bank

Accumulates the six per-cycle top-down increment pulses (base, icache, bpred, dcache, execute, dependency) into live counters. It captures them into software-visible snapshot registers, either on request or at the end of a programmable sampling window. It sits directly downstream of the top-down event classifier and upstream of the CSR/debug read path. Counters are independent: any number may increment in the same cycle.

## Interface
- CNT_WIDTH, 32, width of each live and snapshot counter
- WIN_WIDTH, 16, width of window length and window cycle counter
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- base_comp_incr_i  in  1  base component increment pulse (index 0)
- icache_comp_incr_i  in  1  icache component increment (index 1)
- bpred_comp_incr_i  in  1  branch-predictor component increment (index 2)
- dcache_comp_incr_i  in  1  dcache component increment (index 3)
- ex_comp_incr_i  in  1  execute component increment (index 4)
- dependency_comp_incr_i  in  1  dependency component increment (index 5)
- count_en_i  in  1  counting enable; live counters and window counter hold when low
- clear_i  in  1  synchronous clear of live counters, window counter and overflow flags
- window_len_i  in  WIN_WIDTH  window length in enabled cycles; 0 disables windowing
- snap_req_i  in  1  software snapshot request (single-cycle pulse)
- snap_ack_i  in  1  consumer acknowledges the current snapshot
- rd_idx_i  in  3  snapshot select, 0..5
- rd_data_o  out  CNT_WIDTH  snapshot value of component rd_idx_i; 0 for idx 6,7
- ovf_o  out  6  sticky per-component live-counter wrap flags
- snap_valid_o  out  1  snapshot registers hold unacknowledged data
- snap_overrun_o  out  1  sticky: snapshot overwrote unacknowledged data
- window_done_o  out  1  one-cycle pulse after a window-expiry snapshot

## Operation
- Define next[i] = live[i] + (count_en_i & incr[i]), modulo 2^CNT_WIDTH. If live[i] is all-ones and the component increments, live[i] wraps to 0 and ovf_o[i] is set. ovf_o[i] stays set until clear_i or reset.
- Window counter cyc advances by 1 on each cycle with count_en_i=1 and window_len_i!=0.
- Expiry condition: count_en_i=1, window_len_i!=0 and cyc >= window_len_i-1. The >= comparison covers window_len_i being lowered below the current cyc.
- Event priority per cycle: clear_i, then window expiry, then snap_req_i.
- clear_i:
  - live counters, cyc and ovf_o go to 0.
  - Increments and expiry in that cycle are dropped; a simultaneous snap_req_i is dropped.
  - Snapshot registers, snap_valid_o and snap_overrun_o are unchanged.
- Window expiry:
  - snapshot[i] <= next[i].
  - live[i] <= 0 and cyc <= 0.
  - window_done_o pulses next cycle.
  - A simultaneous snap_req_i is absorbed and produces no second snapshot.
- snap_req_i alone:
  - snapshot[i] <= next[i].
  - Live counters continue with next[i]; they are not cleared.
  - Honoured even when count_en_i=0, in which case next = live.
- Snapshot handshake:
  - Any snapshot sets snap_valid_o.
  - snap_ack_i with no snapshot in the same cycle clears it.
  - A snapshot and ack in the same cycle leave it at 1 and do not set overrun.
  - A snapshot while snap_valid_o=1 and snap_ack_i=0 sets snap_overrun_o. Overrun clears only on reset.
- window_len_i=1: expiry on every enabled cycle.
- Changing window_len_i mid-window takes effect in the same cycle.

## Timing
- Reset values: every live counter, snapshot, cyc, rd_data_o, ovf_o, snap_valid_o, snap_overrun_o and window_done_o are 0.
- Assertion of rst_ni at any point, including mid-window, returns to this state asynchronously.
- Increment visible in live state one cycle after the pulse. Live counters are internal.
- Snapshot registers, snap_valid_o, snap_overrun_o and window_done_o are registered and change on the edge ending the triggering cycle.
- rd_data_o is a combinational mux of the snapshot registers by rd_idx_i. It reflects a new snapshot in the cycle after the trigger, the same cycle snap_valid_o rises.
- Window length N: with count_en_i held high from cyc=0, expiry occurs on the N-th enabled cycle. window_done_o is high in cycle N+1 relative to the first counted cycle.

## Test plan
- Reset, count_en_i=1, WIN=0, icache pulse for 5 cycles and dcache for 2, then snap_req_i -> rd_idx 1 reads 5, idx 3 reads 2, others 0, snap_valid_o=1, no window_done_o.
- window_len_i=4, base pulse every cycle -> window_done_o every 4 cycles, rd_idx 0 reads 4 each window, live restarts at 0. Snapshots acked on window_done_o -> snap_overrun_o stays 0.
- CNT_WIDTH=8, 256 dependency pulses -> ovf_o[5]=1, snapshot idx 5 reads 0. Then clear_i -> ovf_o=0, snapshot still 0, snap_valid_o unchanged.
- Expiry and snap_req_i in the same cycle with snap_valid_o=1 and no ack -> one snapshot, snap_overrun_o=1. Repeat with snap_ack_i=1 -> snap_valid_o=1, no overrun.
- count_en_i=0 with pulses on all inputs for 10 cycles, then snap_req_i -> all snapshots equal the pre-disable values, cyc unchanged.
- window_len_i=8 with cyc=6, lower to 3 -> expiry that cycle. Then assert rst_ni low mid-window -> all outputs 0 immediately.

Source files
------------

// File: rtl/topdown_counter_bank_if.sv
// Event, control and snapshot-read signals between the top-down classifier,
// the counter bank and the CSR/debug read path.
interface topdown_counter_bank_if #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned WIN_WIDTH = 16
);
    logic                 base_comp_incr_i;
    logic                 icache_comp_incr_i;
    logic                 bpred_comp_incr_i;
    logic                 dcache_comp_incr_i;
    logic                 ex_comp_incr_i;
    logic                 dependency_comp_incr_i;
    logic                 count_en_i;
    logic                 clear_i;
    logic [WIN_WIDTH-1:0] window_len_i;
    logic                 snap_req_i;
    logic                 snap_ack_i;
    logic [2:0]           rd_idx_i;
    logic [CNT_WIDTH-1:0] rd_data_o;
    logic [5:0]           ovf_o;
    logic                 snap_valid_o;
    logic                 snap_overrun_o;
    logic                 window_done_o;

    modport slave (
        input  base_comp_incr_i, icache_comp_incr_i, bpred_comp_incr_i,
               dcache_comp_incr_i, ex_comp_incr_i, dependency_comp_incr_i,
               count_en_i, clear_i, window_len_i, snap_req_i, snap_ack_i, rd_idx_i,
        output rd_data_o, ovf_o, snap_valid_o, snap_overrun_o, window_done_o
    );

    modport master (
        output base_comp_incr_i, icache_comp_incr_i, bpred_comp_incr_i,
               dcache_comp_incr_i, ex_comp_incr_i, dependency_comp_incr_i,
               count_en_i, clear_i, window_len_i, snap_req_i, snap_ack_i, rd_idx_i,
        input  rd_data_o, ovf_o, snap_valid_o, snap_overrun_o, window_done_o
    );
endinterface

// File: rtl/topdown_counter_bank.sv
// Six live top-down counters with windowed / on-request snapshot capture,
// sticky wrap flags and a valid/ack/overrun snapshot handshake.
module topdown_counter_bank #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned WIN_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    topdown_counter_bank_if.slave  bus
);
    localparam int unsigned NUM_COMP = 6;

    logic [NUM_COMP-1:0]  incr;
    logic [NUM_COMP-1:0]  wrap;
    logic [CNT_WIDTH-1:0] next_cnt [NUM_COMP];

    logic [CNT_WIDTH-1:0] live_q [NUM_COMP];
    logic [CNT_WIDTH-1:0] live_d [NUM_COMP];
    logic [CNT_WIDTH-1:0] snap_q [NUM_COMP];
    logic [CNT_WIDTH-1:0] snap_d [NUM_COMP];
    logic [WIN_WIDTH-1:0] cyc_q, cyc_d;
    logic [NUM_COMP-1:0]  ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 done_q, done_d;

    logic win_on;
    logic expire;
    logic take_snap;

    assign incr = {bus.dependency_comp_incr_i, bus.ex_comp_incr_i, bus.dcache_comp_incr_i,
                   bus.bpred_comp_incr_i, bus.icache_comp_incr_i, bus.base_comp_incr_i};

    // Candidate next value per counter; this is also what any snapshot captures.
    always_comb begin
        for (int unsigned i = 0; i < NUM_COMP; i++) begin
            next_cnt[i] = live_q[i] + CNT_WIDTH'(bus.count_en_i & incr[i]);
            wrap[i]     = bus.count_en_i & incr[i] & (&live_q[i]);
        end
    end

    // >= rather than == so a window shortened below the current count expires at once.
    assign win_on    = |bus.window_len_i;
    assign expire    = bus.count_en_i & win_on & (cyc_q >= (bus.window_len_i - WIN_WIDTH'(1)));
    assign take_snap = ~bus.clear_i & (expire | bus.snap_req_i);

    always_comb begin
        live_d    = live_q;
        snap_d    = snap_q;
        cyc_d     = cyc_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;

        if (bus.clear_i) begin
            for (int unsigned i = 0; i < NUM_COMP; i++) live_d[i] = '0;
            cyc_d = '0;
            ovf_d = '0;
        end else begin
            ovf_d  = ovf_q | wrap;
            done_d = expire;
            for (int unsigned i = 0; i < NUM_COMP; i++) begin
                live_d[i] = expire ? '0 : next_cnt[i];
            end
            if (expire) begin
                cyc_d = '0;
            end else if (bus.count_en_i && win_on) begin
                cyc_d = cyc_q + WIN_WIDTH'(1);
            end
        end

        if (take_snap) begin
            snap_d    = next_cnt;
            valid_d   = 1'b1;
            overrun_d = overrun_q | (valid_q & ~bus.snap_ack_i);
        end else if (bus.snap_ack_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_COMP; i++) begin
                live_q[i] <= '0;
                snap_q[i] <= '0;
            end
            cyc_q     <= '0;
            ovf_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            live_q    <= live_d;
            snap_q    <= snap_d;
            cyc_q     <= cyc_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
        end
    end

    // Read mux; indices 6 and 7 read as zero.
    always_comb begin
        bus.rd_data_o = '0;
        case (bus.rd_idx_i)
            3'd0:    bus.rd_data_o = snap_q[0];
            3'd1:    bus.rd_data_o = snap_q[1];
            3'd2:    bus.rd_data_o = snap_q[2];
            3'd3:    bus.rd_data_o = snap_q[3];
            3'd4:    bus.rd_data_o = snap_q[4];
            3'd5:    bus.rd_data_o = snap_q[5];
            default: bus.rd_data_o = '0;
        endcase
    end

    assign bus.ovf_o          = ovf_q;
    assign bus.snap_valid_o   = valid_q;
    assign bus.snap_overrun_o = overrun_q;
    assign bus.window_done_o  = done_q;
endmodule
